// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encodings for the "101" frame detector
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_GOT1  = 2'd1,
    D_GOT10 = 2'd2
  } det_state_t;

endpackage

// File: rtl/seq_101_core.sv
// rtl/seq_101_core.sv - overlapping "101" Mealy detector, one bit per enabled cycle
module seq_101_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic hit
);

  det_state_t state_q;
  det_state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= D_IDLE;
    end else if (clr) begin
      state_q <= D_IDLE;
    end else if (bit_en) begin
      state_q <= state_d;
    end
  end

  // A hit lands in D_GOT1 so the trailing '1' can start the next match.
  always_comb begin
    state_d = state_q;
    case (state_q)
      D_IDLE:  state_d = bit_in ? D_GOT1 : D_IDLE;
      D_GOT1:  state_d = bit_in ? D_GOT1 : D_GOT10;
      D_GOT10: state_d = bit_in ? D_GOT1 : D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  assign hit = bit_en && (state_q == D_GOT10) && bit_in;

endmodule

// File: rtl/seq_det_frame_ctrl.sv
// rtl/seq_det_frame_ctrl.sv - frame controller: byte intake, MSB-first serialise, match counting
module seq_det_frame_ctrl
  import seq_det_pkg::*;
#(
  parameter int FRAME_BYTES = 4,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  localparam int               BC_W      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  fsm_state_t      state_q;
  fsm_state_t      state_d;
  logic [7:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic            accept;
  logic            start_acc;
  logic            bit_en;
  logic            last_bit;
  logic            hit;

  assign byte_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign accept     = byte_valid && byte_ready;
  assign start_acc  = (state_q == IDLE) && start;
  assign bit_en     = (state_q == SHIFT);
  assign last_bit   = (bit_cnt == 3'd7);

  seq_101_core u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .bit_en (bit_en),
    .bit_in (shift_reg[7]),
    .hit    (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  if (accept) state_d = SHIFT;
      SHIFT: if (last_bit) state_d = (byte_cnt == LAST_BYTE) ? DONE : LOAD;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count and pulse track the same edge that consumes the matching bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= 8'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      match_cnt   <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= hit;
      if (start_acc) begin
        match_cnt <= '0;
        byte_cnt  <= '0;
      end else if (hit && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + 1'b1;
      end
      if (accept) begin
        shift_reg <= byte_data;
        bit_cnt   <= 3'd0;
      end else if (bit_en) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        bit_cnt   <= bit_cnt + 3'd1;
        if (last_bit && (byte_cnt != LAST_BYTE)) begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// tb/tb_seq_det_frame_ctrl.sv - randomized scoreboard bench for seq_det_frame_ctrl (CNT_W 6 and 3)
module tb_seq_det_frame_ctrl;

  localparam int FB = 4;

  logic clk;
  logic rst;
  logic start;
  logic byte_valid;
  logic [7:0] byte_data;
  logic byte_ready6, busy6, match_pulse6, done6;
  logic [5:0] match_cnt6;
  logic byte_ready3, busy3, match_pulse3, done3;
  logic [2:0] match_cnt3;

  typedef struct {
    int cnt6;
    int cnt3;
    int pulses;
    int cycles;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int p6 = 0, p3 = 0, bcyc = 0;
  logic prev_done = 1'b0;
  int last6 = 0, last3 = 0;

  seq_det_frame_ctrl #(.FRAME_BYTES(FB), .CNT_W(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready6), .busy(busy6), .match_pulse(match_pulse6),
    .match_cnt(match_cnt6), .done(done6)
  );

  seq_det_frame_ctrl #(.FRAME_BYTES(FB), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready3), .busy(busy3), .match_pulse(match_pulse3),
    .match_cnt(match_cnt3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  // Reference: scan the frame as one MSB-first bit string for overlapping "101".
  function automatic int count_101(input logic [8*FB-1:0] fr);
    int n = 0;
    for (int i = 8*FB-1; i >= 2; i--)
      if (fr[i] && !fr[i-1] && fr[i-2]) n++;
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Monitor: accumulates pulses/busy cycles and checks each done against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p6 = 0; p3 = 0; bcyc = 0; prev_done = 1'b0;
    end else begin
      if (match_pulse6) p6++;
      if (match_pulse3) p3++;
      if (busy6) bcyc++;
      if (done6) begin
        check("done_width", {31'd0, prev_done}, 0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("match_cnt6", {26'd0, match_cnt6}, e.cnt6);
          check("match_cnt3", {29'd0, match_cnt3}, e.cnt3);
          check("done3", {31'd0, done3}, 1);
          check("pulses6", p6, e.pulses);
          check("pulses3", p3, e.pulses);
          check("done_latency", bcyc, e.cycles);
        end
        p6 = 0; p3 = 0; bcyc = 0;
      end
      prev_done = done6;
    end
  end

  task automatic send_frame(input logic [8*FB-1:0] fr, input int smin, input int smax,
                            input int abort_at, input bit noise);
    int stalls = 0;
    int s;
    int guard;
    int n;
    guard = 0;
    @(negedge clk);
    while (busy6 && guard < 200) begin
      if (noise) begin byte_valid = 1'($urandom_range(0, 1)); byte_data = 8'($urandom); end
      @(negedge clk);
      guard++;
    end
    if (busy6) begin fail_now("idle_wait"); return; end
    check("cnt_hold6", {26'd0, match_cnt6}, last6);
    check("cnt_hold3", {29'd0, match_cnt3}, last3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < FB; k++) begin
      guard = 0;
      @(negedge clk);
      while (!byte_ready6 && guard < 50) begin
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          byte_valid = 1'($urandom_range(0, 1));
          byte_data = 8'($urandom);
        end
        @(negedge clk);
        guard++;
      end
      if (!byte_ready6) begin fail_now("ready_wait"); start = 1'b0; return; end
      s = $urandom_range(smin, smax);
      byte_valid = 1'b0;
      repeat (s) begin
        check("ready_stall", {31'd0, byte_ready6}, 1);
        @(negedge clk);
      end
      stalls += s;
      byte_valid = 1'b1;
      byte_data = fr[8*(FB-1-k) +: 8];
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      start = 1'b0;
      if (k == abort_at) begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy6}, 0);
        check("rst_ready", {31'd0, byte_ready6}, 0);
        check("rst_cnt6", {26'd0, match_cnt6}, 0);
        check("rst_cnt3", {29'd0, match_cnt3}, 0);
        check("rst_done", {31'd0, done6}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        last6 = 0;
        last3 = 0;
        return;
      end
    end
    n = count_101(fr);
    exp_q.push_back('{cnt6: sat(n, 6), cnt3: sat(n, 3), pulses: n, cycles: 1 + 9*FB + stalls});
    last6 = sat(n, 6);
    last3 = sat(n, 3);
  endtask

  initial begin
    int guard;
    logic [31:0] r;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    #12;
    check("reset_busy", {31'd0, busy6}, 0);
    check("reset_ready", {31'd0, byte_ready6}, 0);
    check("reset_cnt", {26'd0, match_cnt6}, 0);
    check("reset_pulse", {31'd0, match_pulse6}, 0);
    check("reset_done", {31'd0, done6}, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    send_frame(32'hA500_0000, 0, 0, -1, 1'b0);
    send_frame(32'h0140_0000, 0, 0, -1, 1'b0);
    send_frame(32'hAAAA_AAAA, 0, 0, -1, 1'b0);
    send_frame(32'h0000_0002, 0, 0, -1, 1'b0);
    send_frame(32'h8000_0000, 0, 0, -1, 1'b0);
    send_frame(32'hA500_0000, 5, 5, -1, 1'b0);
    send_frame(32'hAAAA_AAAA, 0, 2, 2, 1'b0);
    send_frame(32'hA500_0000, 0, 1, -1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      r = $urandom;
      if (i % 3 == 1) r = r | 32'hAAAA_AAAA;
      if (i % 3 == 2) r = r & $urandom;
      send_frame(r, 0, 3, -1, 1'(i % 2));
    end
    send_frame(32'h5555_5555, 0, 0, 1, 1'b1);
    send_frame(32'hB6DB_6DB6, 0, 2, -1, 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
